// File: rtl/shift_sequencer_if.sv
// Command/result handshake bundle for shift_sequencer.
// The slave modport is the sequencer side; the master modport is the producer/consumer side.
interface shift_sequencer_if;
    logic       IN_VALID;
    logic       IN_READY;
    logic [3:0] IN_DATA;
    logic [1:0] IN_OP;
    logic [2:0] IN_AMT;
    logic       IN_DIR;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [3:0] OUT_DATA;
    logic       BUSY;

    modport slave (
        input  IN_VALID, IN_DATA, IN_OP, IN_AMT, IN_DIR, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA, BUSY
    );

    modport master (
        output IN_VALID, IN_DATA, IN_OP, IN_AMT, IN_DIR, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA, BUSY
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle 4-bit shift/rotate sequencer, one 1-bit step per RUN cycle.
// Define SHIFT_SEQ_LEFT_EN to honour IN_DIR (left steps); otherwise all steps go right.
module shift_sequencer (
    input  logic                  CLK,
    input  logic                  RST,
    shift_sequencer_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_PASS   = 2'b00;
    localparam logic [1:0] OP_SHIFT  = 2'b01;
    localparam logic [1:0] OP_ROTATE = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_work;
    logic [3:0] w_work_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic [1:0] r_op;
    logic       w_accept;
    logic       w_left;
    logic [3:0] w_step;

    assign w_accept = (r_state == IDLE) && bus.IN_VALID;

`ifdef SHIFT_SEQ_LEFT_EN
    logic r_dir;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_dir <= 1'b0;
        end else if (w_accept) begin
            r_dir <= bus.IN_DIR;
        end
    end

    assign w_left = r_dir;
`else
    logic w_unused_dir;

    assign w_unused_dir = bus.IN_DIR;
    assign w_left       = 1'b0;
`endif

    // Single-bit step of the working register; only shift and rotate ever reach RUN
    always_comb begin
        w_step = r_work;
        if (w_left) begin
            if (r_op == OP_ROTATE) w_step = {r_work[2:0], r_work[3]};
            else                   w_step = {r_work[2:0], 1'b0};
        end else begin
            if (r_op == OP_ROTATE) w_step = {r_work[0], r_work[3:1]};
            else                   w_step = {1'b0, r_work[3:1]};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= IDLE;
            r_work  <= 4'b0000;
            r_cnt   <= 3'd0;
            r_op    <= OP_PASS;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_op <= bus.IN_OP;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.IN_VALID) begin
                    w_work_nxt = (bus.IN_OP == OP_CLEAR) ? 4'b0000 : bus.IN_DATA;
                    if (bus.IN_OP == OP_PASS || bus.IN_OP == OP_CLEAR || bus.IN_AMT == 3'd0) begin
                        w_state_nxt = DONE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = bus.IN_AMT;
                    end
                end
            end
            RUN: begin
                w_work_nxt = w_step;
                w_cnt_nxt  = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.OUT_READY) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.IN_READY  = (r_state == IDLE);
    assign bus.OUT_VALID = (r_state == DONE);
    assign bus.OUT_DATA  = (r_state == DONE) ? r_work : 4'b0000;
    assign bus.BUSY      = (r_state != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer; expected values are hand-computed.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_shift_sequencer;

    logic CLK;
    logic RST;
    int   totalChecks;
    int   badChecks;

    shift_sequencer_if bus ();

    shift_sequencer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command and wait (bounded) for OUT_VALID; lat counts cycles after accept
    task automatic applyStimulus(input logic [3:0] d, input logic [1:0] op, input logic [2:0] amt,
                                 input logic dir, output int lat, output logic busyOk);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = d;
        bus.IN_OP    = op;
        bus.IN_AMT   = amt;
        bus.IN_DIR   = dir;
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        lat    = 1;
        busyOk = 1'b1;
        while (!bus.OUT_VALID && lat < 20) begin
            if (!bus.BUSY || bus.OUT_DATA != 4'b0000 || bus.IN_READY) busyOk = 1'b0;
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic runCommand(input string tag, input logic [3:0] d, input logic [1:0] op,
                              input logic [2:0] amt, input logic dir,
                              input logic [3:0] expData, input int expLat);
        int   lat;
        logic busyOk;
        applyStimulus(d, op, amt, dir, lat, busyOk);
        checkOutput({tag, "_lat"}, 8'(lat), 8'(expLat));
        checkOutput({tag, "_data"}, {4'b0, bus.OUT_DATA}, {4'b0, expData});
        checkOutput({tag, "_busy"}, {7'b0, busyOk & bus.BUSY}, 8'd1);
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        bus.OUT_READY = 1'b0;
        checkOutput({tag, "_idle"}, {6'b0, bus.IN_READY, bus.OUT_VALID}, 8'b10);
    endtask

    initial begin : mainSeq
        logic [3:0] heldData;
        logic       holdOk;
        logic       sawValid;
        totalChecks   = 0;
        badChecks     = 0;
        RST           = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.IN_DATA   = 4'b0000;
        bus.IN_OP     = 2'b00;
        bus.IN_AMT    = 3'd0;
        bus.IN_DIR    = 1'b0;
        bus.OUT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("rst_in_ready", {7'b0, bus.IN_READY}, 8'd1);
        checkOutput("rst_out_valid", {7'b0, bus.OUT_VALID}, 8'd0);
        checkOutput("rst_busy", {7'b0, bus.BUSY}, 8'd0);
        checkOutput("rst_out_data", {4'b0, bus.OUT_DATA}, 8'd0);
        RST = 1'b1;
        @(negedge CLK);

        runCommand("rot_r1",   4'b1011, 2'b10, 3'd1, 1'b0, 4'b1101, 2);
        runCommand("shf_r3",   4'b1011, 2'b01, 3'd3, 1'b0, 4'b0001, 4);
        runCommand("rot_r5",   4'b1001, 2'b10, 3'd5, 1'b0, 4'b1100, 6);
        runCommand("clr",      4'b1111, 2'b11, 3'd7, 1'b0, 4'b0000, 1);
        runCommand("pass",     4'b0110, 2'b00, 3'd5, 1'b0, 4'b0110, 1);
        runCommand("shf_amt0", 4'b1010, 2'b01, 3'd0, 1'b0, 4'b1010, 1);
        runCommand("shf_r7",   4'b1111, 2'b01, 3'd7, 1'b0, 4'b0000, 8);
        runCommand("rot_r4",   4'b0110, 2'b10, 3'd4, 1'b0, 4'b0110, 5);

        // Back-pressure: result must hold while a competing command waits on IN_VALID
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 4'b0101;
        bus.IN_OP    = 2'b00;
        bus.IN_AMT   = 3'd0;
        @(negedge CLK);
        bus.IN_DATA  = 4'b1110;
        heldData     = bus.OUT_DATA;
        holdOk       = 1'b1;
        repeat (5) begin
            if (bus.OUT_DATA != 4'b0101 || bus.IN_READY || !bus.OUT_VALID) holdOk = 1'b0;
            @(negedge CLK);
        end
        checkOutput("hold_first", {4'b0, heldData}, 8'b0101);
        checkOutput("hold_stable", {7'b0, holdOk}, 8'd1);
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        bus.OUT_READY = 1'b0;
        checkOutput("hold_release", {5'b0, bus.IN_READY, bus.OUT_VALID, bus.BUSY}, 8'b100);
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        checkOutput("hold_next_accept", {3'b0, bus.OUT_VALID, bus.OUT_DATA}, 8'h1E);
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        bus.OUT_READY = 1'b0;

        // Reset during the second RUN cycle of a 6-step shift
        sawValid     = 1'b0;
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 4'b1111;
        bus.IN_OP    = 2'b01;
        bus.IN_AMT   = 3'd6;
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        checkOutput("rstrun_run_data", {3'b0, bus.BUSY, bus.OUT_DATA}, 8'h10);
        @(negedge CLK);
        RST = 1'b0;
        sawValid = sawValid | bus.OUT_VALID;
        @(negedge CLK);
        RST = 1'b1;
        checkOutput("rstrun_idle", {5'b0, bus.IN_READY, bus.BUSY, bus.OUT_VALID}, 8'b100);
        checkOutput("rstrun_data", {4'b0, bus.OUT_DATA}, 8'd0);
        repeat (8) begin
            sawValid = sawValid | bus.OUT_VALID;
            @(negedge CLK);
        end
        checkOutput("rstrun_no_valid", {7'b0, sawValid}, 8'd0);

`ifdef SHIFT_SEQ_LEFT_EN
        runCommand("rot_dir1", 4'b1000, 2'b10, 3'd1, 1'b1, 4'b0001, 2);
        runCommand("shf_l2",   4'b0111, 2'b01, 3'd2, 1'b1, 4'b1100, 3);
`else
        runCommand("rot_dir1", 4'b1000, 2'b10, 3'd1, 1'b1, 4'b0100, 2);
        runCommand("shf_l2",   4'b0111, 2'b01, 3'd2, 1'b1, 4'b0001, 3);
`endif

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have ports (clock and reset first):
- CLK  input  1  sole clock; all state updates on rising edge
- RST  input  1  synchronous, active-low reset
- IN_VALID  input  1  command valid
- IN_READY  output  1  sequencer can accept a command
- IN_DATA  input  4  operand
- IN_OP  input  2  00 pass, 01 logical shift, 10 rotate, 11 clear
- IN_AMT  input  3  step count, 0..7
- IN_DIR  input  1  0 right, 1 left (see REQ-017)
- OUT_VALID  output  1  result valid
- OUT_READY  input  1  consumer accepts result
- OUT_DATA  output  4  result
- BUSY  output  1  high whenever state is not IDLE
REQ-002 SHALL use one clock; reset is synchronous and active-low.

Function
REQ-003 SHALL implement FSM states IDLE, RUN and DONE; IN_READY = 1 only in IDLE.
REQ-004 IDLE: on IN_VALID=1, SHALL latch IN_DATA into the working register and latch op, amount and direction (command accepted).
REQ-005 From IDLE, an accepted command with op pass, op clear, or IN_AMT=0 SHALL go to DONE; clear loads 0000 into the working register, pass and amount-0 keep IN_DATA.
REQ-006 Otherwise an accepted command SHALL go to RUN with step counter = IN_AMT.
REQ-007 RUN: each cycle SHALL apply exactly one 1-bit step and decrement the counter; on the step where counter=1, SHALL go to DONE.
REQ-008 1-bit right step: shift {0,W[3:1]}; rotate {W[0],W[3:1]}.
REQ-009 Amounts >= 4 SHALL be iterated literally (shift to 0000; rotate modulo 4 by result, not by cycle count).
REQ-010 Latency: OUT_VALID SHALL rise 1 cycle after the accept cycle for pass, clear or amount 0, and N+1 cycles after it for amount N.
REQ-011 DONE: OUT_VALID=1 and OUT_DATA=working register, both held stable until OUT_READY=1; that edge SHALL return to IDLE.
REQ-012 No new command SHALL be accepted in RUN or DONE; IN_VALID there is ignored and needs no hold by the sequencer.
REQ-013 OUT_DATA outside DONE SHALL be 0000.

Reset
REQ-014 RST=0 at a rising edge SHALL force IDLE, counter 0, working register 0000.
REQ-015 Reset outputs: IN_READY=1, OUT_VALID=0, BUSY=0, OUT_DATA=0000.
REQ-016 Reset in RUN or DONE SHALL discard the command with no OUT_VALID pulse; reset overrides any concurrent handshake.

Configuration
REQ-017 Macro SHIFT_SEQ_LEFT_EN defined: IN_DIR=1 SHALL select left steps (shift {W[2:0],0}, rotate {W[2:0],W[3]}).
REQ-018 SHIFT_SEQ_LEFT_EN undefined: IN_DIR SHALL be ignored and all steps are right steps; all other behaviour identical.

Verification
REQ-019 The bench SHALL cover:
- Rotate right, IN_DATA=1011, AMT=1 -> OUT_DATA=1101, OUT_VALID 2 cycles after accept.
- Shift right, IN_DATA=1011, AMT=3 -> OUT_DATA=0001, OUT_VALID 4 cycles after accept, BUSY high throughout.
- Rotate right, IN_DATA=1001, AMT=5 -> OUT_DATA=1100 after 6 cycles; clear with IN_DATA=1111, AMT=7 -> 0000 after 1 cycle.
- OUT_READY held 0 for 5 cycles in DONE -> OUT_DATA stable, IN_READY=0; new IN_VALID not accepted until 1 cycle after OUT_READY=1.
- RST=0 in the 2nd RUN cycle of a shift, AMT=6 -> next cycle IDLE, OUT_VALID never asserted, OUT_DATA=0000.
- SHIFT_SEQ_LEFT_EN defined, rotate, IN_DATA=1000, DIR=1, AMT=1 -> 0001; undefined, same stimulus -> 0100.
